// File: rtl/gt_drp_responder.sv
// DRP responder: a bank of 16-bit registers behind a ce-strobed DRP port,
// plus a local parallel port that reads and writes the same registers on
// every clock.
module gt_drp_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned LATENCY     = 2,
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] drp_address,
  input  logic                  drp_en,
  input  logic                  drp_we,
  input  logic [15:0]           drp_di,
  output logic [15:0]           drp_do,
  output logic                  drp_ready,
  input  logic [ADDR_WIDTH-1:0] local_addr,
  input  logic                  local_we,
  input  logic [15:0]           local_d,
  output logic [15:0]           local_q,
  output logic                  busy,
  output logic                  err_overlap,
  output logic                  err_range,
  input  logic                  err_clear
);

  localparam int unsigned IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e state_q, state_d;

  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic                  cap_we_q;
  logic [15:0]           cap_di_q;
  logic [15:0]           drp_do_q;
  logic [15:0]           local_q_q;
  logic                  err_overlap_q;
  logic                  err_range_q;
  logic [15:0]           regs_q [NREGS];

  logic                  accept;
  logic                  commit;
  logic                  overlap_evt;

  logic                  drp_in_range;
  logic                  local_in_range;
  logic [IDXW-1:0]       drp_idx;
  logic [IDXW-1:0]       local_idx;
  logic [15:0]           drp_rd_data;
  logic [15:0]           local_rd_data;

  // Address decode and read muxes; out-of-range reads return zero.
  always_comb begin
    drp_in_range   = ({1'b0, cap_addr_q} < (ADDR_WIDTH+1)'(NREGS));
    local_in_range = ({1'b0, local_addr} < (ADDR_WIDTH+1)'(NREGS));
    drp_idx        = cap_addr_q[IDXW-1:0];
    local_idx      = local_addr[IDXW-1:0];
    drp_rd_data    = drp_in_range   ? regs_q[drp_idx]   : '0;
    local_rd_data  = local_in_range ? regs_q[local_idx] : '0;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; moves only on ce ticks.
  always_comb begin
    state_d = state_q;
    if (ce) begin
      unique case (state_q)
        S_IDLE:  if (drp_en) state_d = S_WAIT;
        S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
        S_RESP:  state_d = drp_en ? S_WAIT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and per-tick strobes. Ready is simply "in RESP": RESP
  // lasts exactly one ce-tick interval, so the pulse needs no extra flop.
  always_comb begin
    accept      = ce && drp_en && ((state_q == S_IDLE) || (state_q == S_RESP));
    commit      = ce && (state_q == S_WAIT) && (cnt_q == '0);
    overlap_evt = ce && drp_en && (state_q == S_WAIT);
    busy        = (state_q != S_IDLE);
    drp_ready   = (state_q == S_RESP);
  end

  // Latency counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = 4'(LATENCY - 1);
    else if (ce && (state_q == S_WAIT) && (cnt_q != '0))
      cnt_d = cnt_q - 4'd1;
  end

  // Counter and captured transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_we_q   <= 1'b0;
      cap_di_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        cap_addr_q <= drp_address;
        cap_we_q   <= drp_we;
        cap_di_q   <= drp_di;
      end
    end
  end

  // Register bank; the DRP write is issued last so it wins a same-address
  // collision with the local port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      if (local_we && local_in_range) regs_q[local_idx] <= local_d;
      if (commit && cap_we_q && drp_in_range) regs_q[drp_idx] <= cap_di_q;
    end
  end

  // Registered read data for both ports (pre-write register contents).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drp_do_q  <= '0;
      local_q_q <= '0;
    end else begin
      local_q_q <= local_rd_data;
      if (commit && !cap_we_q) drp_do_q <= drp_rd_data;
    end
  end

  // Sticky error flags; a same-clock error event beats err_clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_overlap_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      if (overlap_evt)          err_overlap_q <= 1'b1;
      else if (err_clear)       err_overlap_q <= 1'b0;
      if (commit && !drp_in_range) err_range_q <= 1'b1;
      else if (err_clear)          err_range_q <= 1'b0;
    end
  end

  assign drp_do      = drp_do_q;
  assign local_q     = local_q_q;
  assign err_overlap = err_overlap_q;
  assign err_range   = err_range_q;

endmodule

// File: tb/tb_gt_drp_responder.sv
// Self-checking bench for gt_drp_responder: directed scenarios followed by
// randomized DRP/local traffic compared against an array model.
module tb_gt_drp_responder;

  localparam int unsigned AW  = 9;
  localparam int unsigned NR  = 32;
  localparam int unsigned LAT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          ce;
  logic [AW-1:0] drp_address;
  logic          drp_en;
  logic          drp_we;
  logic [15:0]   drp_di;
  logic [15:0]   drp_do;
  logic          drp_ready;
  logic [AW-1:0] local_addr;
  logic          local_we;
  logic [15:0]   local_d;
  logic [15:0]   local_q;
  logic          busy;
  logic          err_overlap;
  logic          err_range;
  logic          err_clear;

  int checks = 0;
  int errors = 0;

  logic [15:0] m [NR];
  logic [15:0] last_do;
  logic        exp_range;

  gt_drp_responder #(
    .ADDR_WIDTH (AW),
    .NREGS      (NR),
    .LATENCY    (LAT),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .drp_address(drp_address),
    .drp_en     (drp_en),
    .drp_we     (drp_we),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_ready  (drp_ready),
    .local_addr (local_addr),
    .local_we   (local_we),
    .local_d    (local_d),
    .local_q    (local_q),
    .busy       (busy),
    .err_overlap(err_overlap),
    .err_range  (err_range),
    .err_clear  (err_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  // Seven idle clocks, then one clock with ce high (ce every 8th clock).
  task automatic ce_tick();
    repeat (7) step_clk();
    ce = 1'b1;
    step_clk();
    ce = 1'b0;
  endtask

  // Like ce_tick, but with a local write issued on the ce clock itself.
  task automatic ce_tick_local(input logic [AW-1:0] a, input logic [15:0] d);
    repeat (7) step_clk();
    ce = 1'b1;
    local_we = 1'b1;
    local_addr = a;
    local_d = d;
    step_clk();
    ce = 1'b0;
    local_we = 1'b0;
  endtask

  function automatic logic [15:0] model_rd(input int unsigned a);
    return (a < NR) ? m[a] : 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m[i] = 16'h0000;
    last_do = 16'h0000;
    exp_range = 1'b0;
  endtask

  task automatic local_read(input string tag, input int unsigned a);
    local_addr = AW'(a);
    step_clk();
    chk(tag, local_q, model_rd(a));
  endtask

  task automatic local_write(input int unsigned a, input logic [15:0] d);
    local_addr = AW'(a);
    local_d = d;
    local_we = 1'b1;
    step_clk();
    local_we = 1'b0;
    if (a < NR) m[a] = d;
  endtask

  // Full DRP transaction with latency, pulse-width and data checks.
  task automatic drp_txn(input string tag, input logic we, input int unsigned a,
                         input logic [15:0] d);
    int n;
    drp_address = AW'(a);
    drp_we = we;
    drp_di = d;
    drp_en = 1'b1;
    ce_tick();
    drp_en = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    n = 0;
    do begin
      ce_tick();
      n++;
    end while (!drp_ready && n < 20);
    chk({tag, ".latency"}, n, LAT);
    if (we) begin
      if (a < NR) m[a] = d;
    end else begin
      last_do = model_rd(a);
    end
    if (a >= NR) exp_range = 1'b1;
    chk({tag, ".do"}, drp_do, last_do);
    chk({tag, ".err_range"}, err_range, exp_range);
    ce_tick();
    chk({tag, ".ready_fall"}, drp_ready, 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b0;
    drp_address = '0;
    drp_en = 1'b0;
    drp_we = 1'b0;
    drp_di = '0;
    local_addr = '0;
    local_we = 1'b0;
    local_d = '0;
    err_clear = 1'b0;
    model_reset();

    // Reset state
    repeat (3) step_clk();
    chk("rst.drp_do", drp_do, 0);
    chk("rst.ready", drp_ready, 0);
    chk("rst.local_q", local_q, 0);
    chk("rst.busy", busy, 0);
    chk("rst.errs", {err_overlap, err_range}, 0);
    reset = 1'b0;
    step_clk();

    // Basic write / readback on both ports
    drp_txn("wr3", 1'b1, 3, 16'hA5A5);
    local_read("local3", 3);
    drp_txn("rd3", 1'b0, 3, 16'h0);
    drp_txn("rd4", 1'b0, 4, 16'h0);

    // Overlapping drp_en during WAIT is ignored and flagged
    drp_address = AW'(8); drp_we = 1'b1; drp_di = 16'h0808; drp_en = 1'b1;
    ce_tick();
    drp_address = AW'(9); drp_di = 16'h0909;
    ce_tick();
    drp_en = 1'b0;
    chk("ovl.flag", err_overlap, 1);
    chk("ovl.no_early_ready", drp_ready, 0);
    ce_tick();
    chk("ovl.ready", drp_ready, 1);
    m[8] = 16'h0808;
    ce_tick();
    chk("ovl.ready_fall", drp_ready, 0);
    chk("ovl.idle", busy, 0);
    local_read("ovl.reg8", 8);
    local_read("ovl.reg9", 9);
    err_clear = 1'b1;
    step_clk();
    err_clear = 1'b0;
    chk("ovl.clear", err_overlap, 0);

    // Out-of-range accesses
    drp_txn("wr40", 1'b1, 40, 16'hDEAD);
    drp_txn("rd40", 1'b0, 40, 16'h0);
    for (int i = 0; i < NR; i++) local_read("oor.bank", i);
    err_clear = 1'b1;
    step_clk();
    err_clear = 1'b0;
    exp_range = 1'b0;
    chk("oor.clear", err_range, 0);

    // Same-clock DRP commit and local write
    drp_address = AW'(5); drp_we = 1'b1; drp_di = 16'h1111; drp_en = 1'b1;
    ce_tick();
    drp_en = 1'b0;
    ce_tick();
    ce_tick_local(AW'(5), 16'h2222);
    chk("coll.ready", drp_ready, 1);
    ce_tick();
    m[5] = 16'h1111;
    local_read("coll.same", 5);
    drp_address = AW'(5); drp_we = 1'b1; drp_di = 16'h3333; drp_en = 1'b1;
    ce_tick();
    drp_en = 1'b0;
    ce_tick();
    ce_tick_local(AW'(6), 16'h2222);
    ce_tick();
    m[5] = 16'h3333;
    m[6] = 16'h2222;
    local_read("coll.diff5", 5);
    local_read("coll.diff6", 6);

    // Reset in the middle of a write
    drp_address = AW'(7); drp_we = 1'b1; drp_di = 16'h7777; drp_en = 1'b1;
    ce_tick();
    drp_en = 1'b0;
    repeat (2) step_clk();
    reset = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.ready", drp_ready, 0);
    step_clk();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      ce_tick();
      chk("midrst.no_ready", drp_ready, 0);
    end
    local_read("midrst.reg7", 7);
    local_read("midrst.reg3", 3);
    drp_txn("post_wr7", 1'b1, 7, 16'h4242);
    drp_txn("post_rd7", 1'b0, 7, 16'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      int unsigned op;
      int unsigned a;
      logic [15:0] d;
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, 39);
      d  = 16'($urandom);
      case (op)
        0: drp_txn("rnd.wr", 1'b1, a, d);
        1: drp_txn("rnd.rd", 1'b0, a, d);
        2: begin
          local_write(a, d);
          local_read("rnd.lwr", a);
        end
        default: local_read("rnd.lrd", a);
      endcase
    end
    for (int i = 0; i < NR; i++) local_read("final.bank", i);
    chk("final.err_range", err_range, exp_range);
    chk("final.err_overlap", err_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
